// File: rtl/dmem_map_pkg.sv
// Data-memory map shared by the responder, test programs and the processor bench.
// Holds the MMIO page base, register offsets and TX_STATUS bit positions.
package dmem_map_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

    localparam logic [7:0] OFF_TX_DATA   = 8'h00;
    localparam logic [7:0] OFF_TX_STATUS = 8'h01;
    localparam logic [7:0] OFF_CYCLES    = 8'h02;
    localparam logic [7:0] OFF_SCRATCH   = 8'h03;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_UNMAPPED
    } region_e;

    function automatic logic [31:0] tx_status_word(
        input logic [7:0] cnt,
        input logic       ovf,
        input logic       full,
        input logic       empty
    );
        return {20'b0, cnt, 1'b0, ovf, full, empty};
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory port plus TX byte stream, bundled for the responder.
// slave = responder side, master = processor/consumer side.
interface dmem_responder_if;

    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        err_unmapped;

    modport slave (
        input  address_dmem,
        input  data,
        input  wren,
        input  tx_ready,
        output q_dmem,
        output tx_valid,
        output tx_data,
        output err_unmapped
    );

    modport master (
        output address_dmem,
        output data,
        output wren,
        output tx_ready,
        input  q_dmem,
        input  tx_valid,
        input  tx_data,
        input  err_unmapped
    );

endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the console TX stream.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; contents need no reset, head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO page (TX FIFO, status, cycles, scratch).
// Optional feature macro: CYCLE_COUNTER_EN enables the free-running CYCLES counter.
module dmem_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = dmem_map_pkg::MMIO_BASE_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    import dmem_map_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    region_e         region;
    logic [7:0]      offset;
    logic            mmio_wr;
    logic [31:0]     ram [2**ADDR_WIDTH];
    logic [31:0]     scratch;
    logic            ovf;
    logic            err_unmapped;
    logic [31:0]     cyc_val;
    logic [31:0]     q;

    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [7:0]      fifo_head;

    assign offset = bus.address_dmem[7:0];

    // Address decode into RAM, MMIO page or unmapped space.
    always_comb begin
        region = REGION_UNMAPPED;
        if (bus.address_dmem[31:ADDR_WIDTH] == '0) begin
            region = REGION_RAM;
        end else if (bus.address_dmem[31:8] == MMIO_BASE[31:8]) begin
            region = REGION_MMIO;
        end
    end

    assign mmio_wr = bus.wren && (region == REGION_MMIO);
    assign push    = mmio_wr && (offset == OFF_TX_DATA);
    assign pop     = ~fifo_empty & bus.tx_ready;

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clock),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.data[7:0]),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // RAM stores; contents survive reset.
    always_ff @(posedge clock) begin
        if (bus.wren && (region == REGION_RAM)) begin
            ram[bus.address_dmem[ADDR_WIDTH-1:0]] <= bus.data;
        end
    end

    // Scratch, overflow and unmapped-store error flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scratch      <= '0;
            ovf          <= 1'b0;
            err_unmapped <= 1'b0;
        end else begin
            if (mmio_wr && (offset == OFF_SCRATCH)) begin
                scratch <= bus.data;
            end
            if (mmio_wr && (offset == OFF_TX_STATUS) && bus.data[ST_OVF]) begin
                ovf <= 1'b0;
            end
            if (push && fifo_full && !pop) begin
                ovf <= 1'b1;
            end
            if (bus.wren && (region == REGION_UNMAPPED)) begin
                err_unmapped <= 1'b1;
            end
        end
    end

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycles;
    logic        cyc_wr;

    assign cyc_wr  = mmio_wr && (offset == OFF_CYCLES);
    assign cyc_val = cycles;

    // Free-running cycle counter, zeroed by any store to CYCLES.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
        end else if (cyc_wr) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end
`else
    assign cyc_val = '0;
`endif

    // Load data mux, combinational on the pre-edge state.
    always_comb begin
        q = '0;
        unique case (region)
            REGION_RAM: begin
                q = ram[bus.address_dmem[ADDR_WIDTH-1:0]];
            end
            REGION_MMIO: begin
                unique case (offset)
                    OFF_TX_STATUS: q = tx_status_word(8'(fifo_count), ovf,
                                                      fifo_full, fifo_empty);
                    OFF_CYCLES:    q = cyc_val;
                    OFF_SCRATCH:   q = scratch;
                    default:       q = '0;
                endcase
            end
            default: q = '0;
        endcase
    end

    assign bus.q_dmem       = q;
    assign bus.tx_valid     = ~fifo_empty;
    assign bus.tx_data      = fifo_head;
    assign bus.err_unmapped = err_unmapped;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: RAM, MMIO regs, TX FIFO scoreboard,
// unmapped stores, CYCLES (both CYCLE_COUNTER_EN builds) and async reset.
module tb_dmem_responder;

    import dmem_map_pkg::*;

    localparam logic [31:0] A_TX   = MMIO_BASE_DEFAULT | 32'(OFF_TX_DATA);
    localparam logic [31:0] A_ST   = MMIO_BASE_DEFAULT | 32'(OFF_TX_STATUS);
    localparam logic [31:0] A_CYC  = MMIO_BASE_DEFAULT | 32'(OFF_CYCLES);
    localparam logic [31:0] A_SCR  = MMIO_BASE_DEFAULT | 32'(OFF_SCRATCH);
    localparam logic [31:0] A_M80  = MMIO_BASE_DEFAULT | 32'h80;
    localparam logic [31:0] A_UNM  = 32'h0010_0000;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    dmem_responder_if bus ();

    dmem_responder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;
    logic [7:0] sb [$];
    logic [7:0] mon_exp;

    // Scoreboard: every accepted pop is compared against the expected byte order.
    always @(negedge clock) begin
        if (reset && bus.tx_valid && bus.tx_ready) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL tx_pop: got %h, expected no byte", bus.tx_data);
            end else begin
                mon_exp = sb.pop_front();
                if (bus.tx_data !== mon_exp)
                    $display("FAIL tx_pop: got %h, expected %h", bus.tx_data, mon_exp);
                else
                    passed++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        sync();
        bus.address_dmem = a;
        bus.data         = d;
        bus.wren         = 1'b1;
        @(posedge clock);
        #1;
        bus.wren = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] q);
        sync();
        bus.address_dmem = a;
        bus.wren         = 1'b0;
        @(negedge clock);
        q = bus.q_dmem;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accept);
        if (accept)
            sb.push_back(b);
        store(A_TX, {24'h0, b});
    endtask

    task automatic drain();
        bit done = 0;
        sync();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (!bus.tx_valid)
                done = 1;
        end
        sync();
        bus.tx_ready = 1'b0;
        checks++;
        if (!done)
            $display("FAIL drain_timeout: tx_valid=%b, required 0", bus.tx_valid);
        else
            passed++;
        checks++;
        if (sb.size() != 0)
            $display("FAIL drain_left: %0d bytes left, required 0", sb.size());
        else
            passed++;
    endtask

    task automatic test_reset();
        logic [31:0] q;
        bus.address_dmem = '0;
        bus.data         = '0;
        bus.wren         = 1'b0;
        bus.tx_ready     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00)
            $display("FAIL rst_tx: valid=%b data=%h, required 0/00", bus.tx_valid, bus.tx_data);
        else
            passed++;
        checks++;
        if (bus.err_unmapped !== 1'b0)
            $display("FAIL rst_err: got %b, required 0", bus.err_unmapped);
        else
            passed++;
        @(negedge clock);
        reset = 1'b1;
        load(A_ST, q);
        checks++;
        if (q !== 32'h0000_0001)
            $display("FAIL rst_status: got %h, required 00000001", q);
        else
            passed++;
        load(A_SCR, q);
        checks++;
        if (q !== 32'h0)
            $display("FAIL rst_scratch: got %h, required 0", q);
        else
            passed++;
    endtask

    task automatic test_ram();
        logic [31:0] q;
        store(32'h006, 32'h1234_5678);
        store(32'h005, 32'hDEAD_BEEF);
        store(32'hFFF, 32'hA5A5_0FF0);
        load(32'h005, q);
        checks++;
        if (q !== 32'hDEAD_BEEF)
            $display("FAIL ram_005: got %h, required deadbeef", q);
        else
            passed++;
        load(32'h006, q);
        checks++;
        if (q !== 32'h1234_5678)
            $display("FAIL ram_006: got %h, required 12345678", q);
        else
            passed++;
        load(32'hFFF, q);
        checks++;
        if (q !== 32'hA5A5_0FF0)
            $display("FAIL ram_fff: got %h, required a5a50ff0", q);
        else
            passed++;
        load(A_TX, q);
        checks++;
        if (q !== 32'h0)
            $display("FAIL txdata_read: got %h, required 0", q);
        else
            passed++;
    endtask

    task automatic test_fifo_fill();
        logic [31:0] q;
        for (int i = 0; i < 8; i++)
            push_byte(8'h41 + 8'(i), 1'b1);
        load(A_ST, q);
        checks++;
        if (q !== 32'h0000_0082)
            $display("FAIL fill_status: got %h, required 00000082", q);
        else
            passed++;
        push_byte(8'h49, 1'b0);
        load(A_ST, q);
        checks++;
        if (q !== 32'h0000_0086)
            $display("FAIL ovf_status: got %h, required 00000086", q);
        else
            passed++;
        drain();
        store(A_ST, 32'h4);
        load(A_ST, q);
        checks++;
        if (q !== 32'h0000_0001)
            $display("FAIL ovf_clear: got %h, required 00000001", q);
        else
            passed++;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] q;
        for (int i = 0; i < 8; i++)
            push_byte(8'h61 + 8'(i), 1'b1);
        sync();
        sb.push_back(8'h5A);
        bus.address_dmem = A_TX;
        bus.data         = 32'h5A;
        bus.wren         = 1'b1;
        bus.tx_ready     = 1'b1;
        @(posedge clock);
        #1;
        bus.wren     = 1'b0;
        bus.tx_ready = 1'b0;
        load(A_ST, q);
        checks++;
        if (q !== 32'h0000_0082)
            $display("FAIL full_pushpop: got %h, required 00000082", q);
        else
            passed++;
        drain();
    endtask

    task automatic test_back_to_back();
        sync();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            push_byte(8'(($urandom & 32'hFF)), 1'b1);
        drain();
    endtask

    task automatic test_unmapped();
        logic [31:0] q;
        store(A_M80, 32'h0000_0123);
        @(negedge clock);
        checks++;
        if (bus.err_unmapped !== 1'b0)
            $display("FAIL mmio80_err: got %b, required 0", bus.err_unmapped);
        else
            passed++;
        load(A_M80, q);
        checks++;
        if (q !== 32'h0)
            $display("FAIL mmio80_read: got %h, required 0", q);
        else
            passed++;
        store(A_UNM, 32'h5555_AAAA);
        @(negedge clock);
        checks++;
        if (bus.err_unmapped !== 1'b1)
            $display("FAIL unm_err: got %b, required 1", bus.err_unmapped);
        else
            passed++;
        load(A_UNM, q);
        checks++;
        if (q !== 32'h0)
            $display("FAIL unm_read: got %h, required 0", q);
        else
            passed++;
        load(32'h000, q);
        checks++;
        if (q === 32'h5555_AAAA)
            $display("FAIL unm_alias: got %h, required not 5555aaaa", q);
        else
            passed++;
    endtask

    task automatic test_counter();
        logic [31:0] a;
        logic [31:0] b;
`ifdef CYCLE_COUNTER_EN
        load(A_CYC, a);
        repeat (9) @(posedge clock);
        load(A_CYC, b);
        checks++;
        if (b - a !== 32'd10)
            $display("FAIL cyc_diff: got %0d, required 10", b - a);
        else
            passed++;
        store(A_CYC, 32'h1234);
        load(A_CYC, b);
        checks++;
        if (b !== 32'd1)
            $display("FAIL cyc_clear: got %h, required 1", b);
        else
            passed++;
        sync();
        force dut.cycles = 32'hFFFF_FFFE;
        #1;
        release dut.cycles;
        load(A_CYC, a);
        load(A_CYC, b);
        checks++;
        if (a !== 32'hFFFF_FFFF || b !== 32'h0)
            $display("FAIL cyc_wrap: got %h,%h, required ffffffff,0", a, b);
        else
            passed++;
`else
        load(A_CYC, a);
        repeat (5) @(posedge clock);
        store(A_CYC, 32'h1234);
        load(A_CYC, b);
        checks++;
        if (a !== 32'h0 || b !== 32'h0)
            $display("FAIL cyc_off: got %h,%h, required 0,0", a, b);
        else
            passed++;
`endif
    endtask

    task automatic test_async_reset();
        logic [31:0] q;
        store(A_SCR, 32'hCAFE_F00D);
        load(A_SCR, q);
        checks++;
        if (q !== 32'hCAFE_F00D)
            $display("FAIL scratch_rw: got %h, required cafef00d", q);
        else
            passed++;
        for (int i = 0; i < 3; i++)
            push_byte(8'h31 + 8'(i), 1'b1);
        @(negedge clock);
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h31)
            $display("FAIL pre_rst_head: valid=%b data=%h, required 1/31", bus.tx_valid, bus.tx_data);
        else
            passed++;
        sync();
        bus.tx_ready = 1'b1;
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.err_unmapped !== 1'b0)
            $display("FAIL async_rst: valid=%b data=%h err=%b, required 0/00/0",
                     bus.tx_valid, bus.tx_data, bus.err_unmapped);
        else
            passed++;
        bus.tx_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        load(A_ST, q);
        checks++;
        if (q !== 32'h0000_0001)
            $display("FAIL post_rst_status: got %h, required 00000001", q);
        else
            passed++;
        load(A_SCR, q);
        checks++;
        if (q !== 32'h0)
            $display("FAIL post_rst_scratch: got %h, required 0", q);
        else
            passed++;
        load(32'h005, q);
        checks++;
        if (q !== 32'hDEAD_BEEF)
            $display("FAIL ram_retain: got %h, required deadbeef", q);
        else
            passed++;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_fifo_fill();
        test_full_push_pop();
        test_back_to_back();
        test_unmapped();
        test_counter();
        test_async_reset();
        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
